bf2i_feeder: RTL and testbench
==============================

# bf2i_feeder

Input-side companion of the radix-2 butterfly stage (BF2I). It accepts a stream of DEPTH-lane complex blocks and buffers the first half of each FFT frame. As each second-half block arrives, it pairs that block with its stored first-half partner and drives the butterfly's R1/R2/Q1/Q2 inputs together with the butterfly's `en` strobe.

## Interface
- `WIDTH`, default 9: signed sample width, equal to butterfly input width.
- `DEPTH`, default 16: parallel lanes per block.
- `HALF_BLK`, default 2: blocks per half frame (64-point frame = 4 blocks of 16); legal range ≥1.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `din_valid` in 1: input block present this cycle.
- `din_sof` in 1: qualifies the current block as block 0 of a frame; ignored when `din_valid`=0.
- `din_R` in `[DEPTH-1:0]`×WIDTH signed: real lanes.
- `din_Q` in `[DEPTH-1:0]`×WIDTH signed: imaginary lanes.
- `bf_en` out 1: pair valid; connects to the butterfly's `en`.
- `dout_R1` and `dout_Q1` out `[DEPTH-1:0]`×WIDTH signed: first-half (stored) block.
- `dout_R2` and `dout_Q2` out `[DEPTH-1:0]`×WIDTH signed: second-half (live) block.
- `dout_idx` out max(1,$clog2(HALF_BLK)): block index within half for the current pair.
- `frame_err` out 1: one-cycle pulse when `din_sof` arrives mid-frame.

## Operation
- States:
  - FILL: storing first-half blocks.
  - PAIR: emitting pairs.
- Counter `blk_cnt` runs 0..HALF_BLK-1 and advances only on `din_valid`.
- FILL behaviour:
  - Each valid block is written to `buf[blk_cnt]`.
  - At `blk_cnt`=HALF_BLK-1, the counter goes to 0 and the state goes to PAIR.
- PAIR behaviour:
  - Each valid block is output as R2/Q2, with `buf[blk_cnt]` as R1/Q1.
  - `dout_idx` is set to `blk_cnt`.
  - At HALF_BLK-1, the counter goes to 0 and the state goes to FILL.
- `din_valid`=0 stalls: state and counter hold, and `bf_en`=0. Gaps of any length are legal.
- `din_sof` handling:
  - Accepted silently when the state is FILL and `blk_cnt`=0.
  - Anywhere else: `frame_err` pulses, the partial frame is discarded, and the sof block is written as `buf[0]`. The next state is FILL with `blk_cnt`=1, or PAIR with `blk_cnt`=0 when HALF_BLK=1.
- A block without sof at FILL/0 is accepted as a frame start; sof is not mandatory.
- No arithmetic: values pass unchanged and keep their sign.
- When `bf_en`=0, data outputs hold their last values.

## Timing
- Output latency is 1 cycle. The pair formed from a valid PAIR-state input on cycle n appears registered on cycle n+1, with `bf_en`=1 on n+1 only.
- Butterfly results therefore appear 2 cycles after the second-half input.
- Throughput is one block per cycle. The PAIR→FILL wrap has no bubble: the next frame's block 0 is accepted the cycle after the last pair input.
- `frame_err` is registered, high on the cycle after the offending input.
- Reset values:
  - State FILL, `blk_cnt` 0.
  - `bf_en` 0, `frame_err` 0, `dout_idx` 0.
  - All data outputs 0.
- Buffer contents are not reset.
- Reset mid-frame: the next cycle is FILL/0 and the partial frame is discarded. `rst` has priority over `din_valid`.

## Structure
- Shared package `fft_pkg`:
  - Default `WIDTH`/`DEPTH` localparams.
  - `bf_feed_state_t` enum {FILL, PAIR}.
  - A lane-array typedef for `[DEPTH-1:0]` signed WIDTH.
- Sub-module `bf2i_half_buf`:
  - HALF_BLK×DEPTH×2·WIDTH register storage.
  - Write-enable, write index and combinational read index.
  - No reset on storage.
- The top holds the FSM, counter, and output/error registers.

## Test plan
- Reset then one 64-point frame, contiguous, with lane i of block b: R=b*16+i, Q=-(b*16+i). Required: `bf_en` high on 2 cycles; pair 0 has R1=i, R2=32+i, `dout_idx`=0; pair 1 has R1=16+i, R2=48+i, `dout_idx`=1.
- Same frame with `din_valid` gaps of 0–3 random cycles. Required: identical pair values, `bf_en` only on the cycle after each PAIR input.
- Two back-to-back frames with no idle cycle. Required: 4 pairs total; frame-2 pairs use only frame-2 data.
- Sof on the second block of a frame. Required: `frame_err` is a 1-cycle pulse, no `bf_en` from the discarded partial frame, and a correct frame follows starting from the sof block.
- `rst` asserted while in PAIR after 1 pair. Required: next cycle all outputs 0, then a fresh full frame pairs correctly.
- HALF_BLK=1, plus extremes R=-256/255 on DEPTH lanes. Required: pairs every second block, with values passed bit-exact.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath types: default lane geometry, feeder states, lane arrays.
// Latency: none (types and helpers only).
// Backpressure: not applicable.
package fft_pkg;

  localparam int FFT_WIDTH = 9;
  localparam int FFT_DEPTH = 16;

  typedef enum logic {FILL, PAIR} bf_feed_state_t;

  typedef logic signed [FFT_DEPTH-1:0][FFT_WIDTH-1:0] lane_arr_t;

  // Index width for a HALF_BLK-deep buffer; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bf2i_half_buf.sv
// First-half block store: HALF_BLK entries of DEPTH complex lanes.
// Latency: 1-cycle write, combinational read.
// Backpressure: none; writes whenever wr_en is high.
module bf2i_half_buf
  import fft_pkg::*;
#(
  parameter int WIDTH    = FFT_WIDTH,
  parameter int DEPTH    = FFT_DEPTH,
  parameter int HALF_BLK = 2,
  parameter int IDXW     = 1
) (
  input  logic                               clk,
  input  logic                               wr_en,
  input  logic [IDXW-1:0]                    wr_idx,
  input  logic signed [DEPTH-1:0][WIDTH-1:0] wr_R,
  input  logic signed [DEPTH-1:0][WIDTH-1:0] wr_Q,
  input  logic [IDXW-1:0]                    rd_idx,
  output logic signed [DEPTH-1:0][WIDTH-1:0] rd_R,
  output logic signed [DEPTH-1:0][WIDTH-1:0] rd_Q
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_r [HALF_BLK];
  logic [DEPTH-1:0][WIDTH-1:0] mem_q [HALF_BLK];

  // Storage is deliberately not reset; the FSM never reads an unwritten entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= wr_R;
      mem_q[wr_idx] <= wr_Q;
    end
  end

  assign rd_R = mem_r[rd_idx];
  assign rd_Q = mem_q[rd_idx];

endmodule

// File: rtl/bf2i_feeder.sv
// Pairs stored first-half blocks with live second-half blocks for the BF2I butterfly.
// Latency: 1 cycle from second-half input to registered pair with bf_en.
// Backpressure: none; din_valid low stalls the FSM, one block accepted per cycle.
module bf2i_feeder
  import fft_pkg::*;
#(
  parameter int WIDTH    = FFT_WIDTH,
  parameter int DEPTH    = FFT_DEPTH,
  parameter int HALF_BLK = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 din_valid,
  input  logic                                 din_sof,
  input  logic signed [DEPTH-1:0][WIDTH-1:0]   din_R,
  input  logic signed [DEPTH-1:0][WIDTH-1:0]   din_Q,
  output logic                                 bf_en,
  output logic signed [DEPTH-1:0][WIDTH-1:0]   dout_R1,
  output logic signed [DEPTH-1:0][WIDTH-1:0]   dout_Q1,
  output logic signed [DEPTH-1:0][WIDTH-1:0]   dout_R2,
  output logic signed [DEPTH-1:0][WIDTH-1:0]   dout_Q2,
  output logic [idx_width(HALF_BLK)-1:0]       dout_idx,
  output logic                                 frame_err
);

  localparam int              IDXW = idx_width(HALF_BLK);
  localparam logic [IDXW-1:0] LAST = IDXW'(HALF_BLK - 1);

  bf_feed_state_t                   state;
  logic [IDXW-1:0]                  blk_cnt;
  logic                             sof_err;
  logic                             buf_we;
  logic [IDXW-1:0]                  buf_widx;
  logic signed [DEPTH-1:0][WIDTH-1:0] rd_R;
  logic signed [DEPTH-1:0][WIDTH-1:0] rd_Q;

  // A sof anywhere but FILL/0 restarts the frame with this block as entry 0.
  assign sof_err  = din_valid && din_sof && !(state == FILL && blk_cnt == '0);
  assign buf_we   = din_valid && (state == FILL || sof_err);
  assign buf_widx = sof_err ? '0 : blk_cnt;

  bf2i_half_buf #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .HALF_BLK (HALF_BLK),
    .IDXW     (IDXW)
  ) u_buf (
    .clk    (clk),
    .wr_en  (buf_we),
    .wr_idx (buf_widx),
    .wr_R   (din_R),
    .wr_Q   (din_Q),
    .rd_idx (blk_cnt),
    .rd_R   (rd_R),
    .rd_Q   (rd_Q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      blk_cnt   <= '0;
      bf_en     <= 1'b0;
      frame_err <= 1'b0;
      dout_idx  <= '0;
      dout_R1   <= '0;
      dout_Q1   <= '0;
      dout_R2   <= '0;
      dout_Q2   <= '0;
    end else begin
      bf_en     <= 1'b0;
      frame_err <= 1'b0;
      if (din_valid) begin
        if (sof_err) begin
          frame_err <= 1'b1;
          if (HALF_BLK == 1) begin
            state   <= PAIR;
            blk_cnt <= '0;
          end else begin
            state   <= FILL;
            blk_cnt <= IDXW'(1);
          end
        end else begin
          if (state == PAIR) begin
            bf_en    <= 1'b1;
            dout_R1  <= rd_R;
            dout_Q1  <= rd_Q;
            dout_R2  <= din_R;
            dout_Q2  <= din_Q;
            dout_idx <= blk_cnt;
          end
          // Wrap toggles between halves with no bubble.
          if (blk_cnt == LAST) begin
            blk_cnt <= '0;
            state   <= (state == FILL) ? PAIR : FILL;
          end else begin
            blk_cnt <= blk_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bf2i_feeder.sv
// Directed bench for bf2i_feeder: default geometry plus a HALF_BLK=1 instance.
module tb_bf2i_feeder;
  import fft_pkg::*;

  typedef logic signed [15:0][8:0] lane_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  din_valid = 1'b0;
  logic  din_sof = 1'b0;
  lane_t din_R = '0;
  lane_t din_Q = '0;

  logic  bf_en, frame_err;
  lane_t dout_R1, dout_Q1, dout_R2, dout_Q2;
  logic  dout_idx;
  logic  h_bf_en, h_frame_err;
  lane_t h_R1, h_Q1, h_R2, h_Q2;
  logic  h_idx;

  int checks = 0;
  int errors = 0;
  int pairs  = 0;

  always #5 clk = ~clk;

  bf2i_feeder #(.WIDTH(9), .DEPTH(16), .HALF_BLK(2)) u0 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_sof(din_sof),
    .din_R(din_R), .din_Q(din_Q), .bf_en(bf_en),
    .dout_R1(dout_R1), .dout_Q1(dout_Q1), .dout_R2(dout_R2), .dout_Q2(dout_Q2),
    .dout_idx(dout_idx), .frame_err(frame_err)
  );

  bf2i_feeder #(.WIDTH(9), .DEPTH(16), .HALF_BLK(1)) u1 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_sof(din_sof),
    .din_R(din_R), .din_Q(din_Q), .bf_en(h_bf_en),
    .dout_R1(h_R1), .dout_Q1(h_Q1), .dout_R2(h_R2), .dout_Q2(h_Q2),
    .dout_idx(h_idx), .frame_err(h_frame_err)
  );

  function automatic lane_t blk_r(input int b);
    lane_t r;
    for (int i = 0; i < 16; i++) r[i] = 9'(b * 16 + i);
    return r;
  endfunction

  function automatic lane_t blk_q(input int b);
    lane_t q;
    for (int i = 0; i < 16; i++) q[i] = 9'(-(b * 16 + i));
    return q;
  endfunction

  function automatic lane_t ext(input int pat);
    lane_t e;
    for (int i = 0; i < 16; i++) e[i] = ((i + pat) % 2 == 1) ? 9'sd255 : -9'sd256;
    return e;
  endfunction

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic drive(input logic v, input logic s, input lane_t r, input lane_t q);
    din_valid = v;
    din_sof   = s;
    din_R     = r;
    din_Q     = q;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input string name, input int base, input int max_gap);
    int gap;
    for (int b = 0; b < 4; b++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 1'b0, din_R, din_Q);
        checks++;
        if (bf_en !== 1'b0 || frame_err !== 1'b0) begin
          errors++;
          $display("FAIL %s gap b%0d bf_en=%b frame_err=%b want 0/0", name, b, bf_en, frame_err);
        end
      end
      drive(1'b1, b == 0, blk_r(base + b), blk_q(base + b));
      checks++;
      if (bf_en !== (b >= 2) || frame_err !== 1'b0) begin
        errors++;
        $display("FAIL %s en b%0d bf_en=%b frame_err=%b want %b/0", name, b, bf_en, frame_err, b >= 2);
      end
      if (b >= 2) begin
        pairs++;
        checks++;
        if (dout_R1 !== blk_r(base + b - 2) || dout_Q1 !== blk_q(base + b - 2) ||
            dout_R2 !== blk_r(base + b) || dout_Q2 !== blk_q(base + b) ||
            dout_idx !== 1'(b - 2)) begin
          errors++;
          $display("FAIL %s pair b%0d R1=%h R2=%h idx=%b want R1=%h R2=%h idx=%0d",
                   name, b, dout_R1, dout_R2, dout_idx, blk_r(base + b - 2), blk_r(base + b), b - 2);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, '0, '0);
    checks++;
    if (bf_en !== 1'b0 || frame_err !== 1'b0 || dout_idx !== 1'b0 ||
        dout_R1 !== '0 || dout_Q1 !== '0 || dout_R2 !== '0 || dout_Q2 !== '0) begin
      errors++;
      $display("FAIL reset u0 en=%b err=%b idx=%b R1=%h R2=%h want all 0", bf_en, frame_err, dout_idx, dout_R1, dout_R2);
    end
    checks++;
    if (h_bf_en !== 1'b0 || h_frame_err !== 1'b0 || h_idx !== 1'b0 ||
        h_R1 !== '0 || h_Q1 !== '0 || h_R2 !== '0 || h_Q2 !== '0) begin
      errors++;
      $display("FAIL reset u1 en=%b err=%b idx=%b R1=%h R2=%h want all 0", h_bf_en, h_frame_err, h_idx, h_R1, h_R2);
    end
    rst = 1'b0;
  endtask

  task automatic test_frame();
    run_frame("frame", 0, 0);
    drive(1'b0, 1'b0, blk_r(9), blk_q(9));
    checks++;
    if (bf_en !== 1'b0 || dout_R2 !== blk_r(3) || dout_Q1 !== blk_q(1) || dout_idx !== 1'b1) begin
      errors++;
      $display("FAIL hold en=%b R2=%h idx=%b want 0 %h 1", bf_en, dout_R2, dout_idx, blk_r(3));
    end
  endtask

  task automatic test_gaps();
    run_frame("gaps", 0, 3);
    run_frame("gaps2", 4, 3);
  endtask

  task automatic test_back_to_back();
    pairs = 0;
    run_frame("b2b_f1", 0, 0);
    run_frame("b2b_f2", 4, 0);
    checks++;
    if (pairs !== 4) begin
      errors++;
      $display("FAIL b2b_pairs got %0d want 4", pairs);
    end
  endtask

  task automatic test_sof_err();
    drive(1'b1, 1'b1, blk_r(0), blk_q(0));
    checks++;
    if (bf_en !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL sof_first en=%b err=%b want 0/0", bf_en, frame_err);
    end
    drive(1'b1, 1'b1, blk_r(8), blk_q(8));
    checks++;
    if (bf_en !== 1'b0 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL sof_mid en=%b err=%b want 0/1", bf_en, frame_err);
    end
    drive(1'b1, 1'b0, blk_r(9), blk_q(9));
    checks++;
    if (bf_en !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL sof_pulse en=%b err=%b want 0/0", bf_en, frame_err);
    end
    for (int b = 0; b < 2; b++) begin
      drive(1'b1, 1'b0, blk_r(10 + b), blk_q(10 + b));
      checks++;
      if (bf_en !== 1'b1 || frame_err !== 1'b0 || dout_R1 !== blk_r(8 + b) ||
          dout_Q1 !== blk_q(8 + b) || dout_R2 !== blk_r(10 + b) ||
          dout_Q2 !== blk_q(10 + b) || dout_idx !== 1'(b)) begin
        errors++;
        $display("FAIL sof_pair%0d en=%b R1=%h R2=%h idx=%b want 1 %h %h %0d",
                 b, bf_en, dout_R1, dout_R2, dout_idx, blk_r(8 + b), blk_r(10 + b), b);
      end
    end
  endtask

  task automatic test_rst_mid();
    for (int b = 0; b < 3; b++) drive(1'b1, b == 0, blk_r(b), blk_q(b));
    checks++;
    if (bf_en !== 1'b1 || dout_R2 !== blk_r(2)) begin
      errors++;
      $display("FAIL rst_pre en=%b R2=%h want 1 %h", bf_en, dout_R2, blk_r(2));
    end
    rst = 1'b1;
    drive(1'b1, 1'b0, blk_r(3), blk_q(3));
    rst = 1'b0;
    checks++;
    if (bf_en !== 1'b0 || frame_err !== 1'b0 || dout_idx !== 1'b0 ||
        dout_R1 !== '0 || dout_Q1 !== '0 || dout_R2 !== '0 || dout_Q2 !== '0) begin
      errors++;
      $display("FAIL rst_mid en=%b err=%b idx=%b R1=%h R2=%h want all 0", bf_en, frame_err, dout_idx, dout_R1, dout_R2);
    end
    run_frame("rst_after", 4, 0);
  endtask

  task automatic test_half1();
    lane_t ar, aq, br, bq;
    ar = ext(0); aq = ext(1); br = ext(1); bq = ext(0);
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    drive(1'b1, 1'b1, ar, aq);
    checks++;
    if (h_bf_en !== 1'b0 || h_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL h1_fill en=%b err=%b want 0/0", h_bf_en, h_frame_err);
    end
    drive(1'b1, 1'b0, br, bq);
    checks++;
    if (h_bf_en !== 1'b1 || h_R1 !== ar || h_Q1 !== aq || h_R2 !== br || h_Q2 !== bq || h_idx !== 1'b0) begin
      errors++;
      $display("FAIL h1_pair0 en=%b R1=%h R2=%h want 1 %h %h", h_bf_en, h_R1, h_R2, ar, br);
    end
    drive(1'b1, 1'b0, br, bq);
    checks++;
    if (h_bf_en !== 1'b0 || h_R2 !== br) begin
      errors++;
      $display("FAIL h1_fill2 en=%b R2=%h want 0 %h", h_bf_en, h_R2, br);
    end
    drive(1'b1, 1'b0, ar, aq);
    checks++;
    if (h_bf_en !== 1'b1 || h_R1 !== br || h_Q1 !== bq || h_R2 !== ar || h_Q2 !== aq) begin
      errors++;
      $display("FAIL h1_pair1 en=%b R1=%h R2=%h want 1 %h %h", h_bf_en, h_R1, h_R2, br, ar);
    end
    drive(1'b1, 1'b1, ar, aq);
    drive(1'b1, 1'b1, br, bq);
    checks++;
    if (h_bf_en !== 1'b0 || h_frame_err !== 1'b1) begin
      errors++;
      $display("FAIL h1_sof_err en=%b err=%b want 0/1", h_bf_en, h_frame_err);
    end
    drive(1'b1, 1'b0, ar, aq);
    checks++;
    if (h_bf_en !== 1'b1 || h_frame_err !== 1'b0 || h_R1 !== br || h_Q1 !== bq || h_R2 !== ar || h_Q2 !== aq) begin
      errors++;
      $display("FAIL h1_after_err en=%b err=%b R1=%h R2=%h want 1 0 %h %h", h_bf_en, h_frame_err, h_R1, h_R2, br, ar);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame();
    test_gaps();
    test_back_to_back();
    test_sof_err();
    test_rst_mid();
    test_half1();
    drive(1'b0, 1'b0, '0, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
